// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built around one full-adder cell.
// One result bit is produced per clock, LSB first. The carry is registered and
// fed back into the cell. A start/busy/done handshake launches a WIDTH-bit
// addition and returns {cout, sum} = a + b + cin.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for start; sum/cout hold the last result
// S_RUN  | one operand bit pair consumed per edge, WIDTH edges in total
// S_DONE | result valid, done high for this one cycle; start may relaunch
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;

    logic w_s;
    logic w_c;
    logic w_accept;
    logic w_last;

    // The single full-adder cell operating on the current LSBs and the stored carry.
    assign w_s = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_c = (r_opa[0] & r_opb[0]) | (r_carry & (r_opa[0] ^ r_opb[0]));

    // Next-state decode and the accept/last strobes that steer the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand shifters, carry, bit counter and result assembly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= a;
            r_opb   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_res   <= '0;
        end else if (r_state == S_RUN) begin
            r_opa   <= r_opa >> 1;
            r_opb   <= r_opb >> 1;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            r_res   <= {w_s, r_res[WIDTH-1:1]};
            // sum/cout only move on the completing edge so they never show partial results.
            if (w_last) begin
                r_sum  <= {w_s, r_res[WIDTH-1:1]};
                r_cout <= w_c;
            end
        end
    end

    // Handshake flags: busy spans the RUN cycles, done pulses once after the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder.
// The driver launches operations and pushes the arithmetic result plus the
// cycle in which done must appear; a monitor pops on every done pulse.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           cyc;
    } exp_t;

    exp_t q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index, advanced on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0 && cyc > q[0].cyc) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done by cycle %0d expected at %0d", cyc, q[0].cyc);
            e = q.pop_front();
        end
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with nothing expected", cyc);
            end else begin
                e = q.pop_front();
                chk("sum", 64'(sum), 64'(e.s));
                chk("cout", 64'(cout), 64'(e.c));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_at_done", 64'(busy), 64'(0));
            end
        end
    end

    // mode: -1 quiet, -2 random start noise during RUN, -3 hold start high,
    // k>=0 inject a start with 0xAA/0x55 on RUN cycle k+1.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic, input int mode);
        exp_t       e;
        logic [W:0] tot;
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = ic;
        tick();
        tot   = {1'b0, ia} + {1'b0, ib} + (W+1)'(ic);
        e.s   = tot[W-1:0];
        e.c   = tot[W];
        e.cyc = cyc + W;
        q.push_back(e);
        for (int i = 0; i < W; i++) begin
            start = (mode == -3);
            chk("busy_run", 64'(busy), 64'(1));
            chk("sum_hold_run", 64'(sum), 64'(last_sum));
            chk("cout_hold_run", 64'(cout), 64'(last_cout));
            if (mode == i) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end else if (mode == -2) begin
                start = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
            end
            tick();
        end
        start = 1'b0;
        chk("busy_done_cycle", 64'(busy), 64'(0));
        chk("done_flag", 64'(done), 64'(1));
        last_sum  = e.s;
        last_cout = e.c;
    endtask

    // Bounds the whole run in case the DUT stalls the driver.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Directed cases followed by randomized operations.
    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'(0));

        // Basic add, then result hold with wiggling inputs.
        run_op(8'h3C, 8'h5A, 1'b0, -1);
        tick();
        for (int i = 0; i < 20; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            tick();
            chk("hold_sum", 64'(sum), 64'(8'h96));
            chk("hold_cout", 64'(cout), 64'(0));
            chk("hold_done", 64'(done), 64'(0));
        end

        // Full carry ripple.
        run_op(8'hFF, 8'h01, 1'b0, -1);
        tick();
        run_op(8'hFF, 8'hFF, 1'b1, -1);
        tick();

        // Start pulsed on RUN cycle 3 must be ignored.
        run_op(8'h10, 8'h20, 1'b0, 2);
        for (int i = 0; i < W + 3; i++) begin
            tick();
            chk("ignored_start_idle", 64'(busy), 64'(0));
        end

        // Back-to-back with start held high.
        run_op(8'h01, 8'h01, 1'b0, -3);
        run_op(8'h80, 8'h80, 1'b0, -1);
        tick();

        // Reset on RUN cycle 4 aborts the operation.
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_cout", 64'(cout), 64'(0));
        last_sum  = '0;
        last_cout = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            chk("abort_no_done", 64'(done), 64'(0));
        end
        run_op(8'h12, 8'h34, 1'b0, -1);
        tick();

        // Randomized operations with random gaps and start noise during RUN.
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   ($urandom_range(0, 1) == 1) ? -2 : -1);
            if ($urandom_range(0, 2) != 0) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end

        start = 1'b0;
        repeat (W + 3) tick();
        chk("scoreboard_empty", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
